usxgmii_rate_adapt_ctrl: RTL and testbench



---
 rtl/usxgmii_rate_adapt_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_usxgmii_rate_adapt_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/usxgmii_rate_adapt_ctrl.sv
// USXGMII receive rate-adaptation controller: locks onto the word replication
// phase, forwards one copy per group and checks the remaining copies.
module usxgmii_rate_adapt_ctrl #(
    parameter int p_ERR_LIMIT     = 4,
    parameter int p_ALIGN_TIMEOUT = 4096,
    parameter int p_ERR_CNT_WIDTH = 16
) (
    input  logic                       i_usxgmii_clock,
    input  logic                       i_usxgmii_reset,
    input  logic                       i_link_up,
    input  logic [2:0]                 i_speed,
    input  logic [3:0]                 i_usxgmii_control,
    input  logic [31:0]                i_usxgmii_data,
    output logic                       o_usxgmii_valid,
    output logic [3:0]                 o_usxgmii_control,
    output logic [31:0]                o_usxgmii_data,
    output logic                       o_locked,
    output logic                       o_speed_invalid,
    output logic [p_ERR_CNT_WIDTH-1:0] o_rep_err_count
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_ALIGN   = 2'd1;
    localparam logic [1:0]  S_RUN     = 2'd2;
    localparam logic [35:0] IDLE_WORD = {4'hF, 32'h0707_0707};
    localparam int          TO_W      = $clog2(p_ALIGN_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(p_ALIGN_TIMEOUT - 1);
    localparam logic [3:0]      ERR_LIM  = 4'(p_ERR_LIMIT);

    function automatic logic [9:0] rep_factor(input logic [2:0] speed);
        case (speed)
            3'd0:    rep_factor = 10'd1000;
            3'd1:    rep_factor = 10'd100;
            3'd2:    rep_factor = 10'd10;
            3'd3:    rep_factor = 10'd4;
            3'd4:    rep_factor = 10'd2;
            default: rep_factor = 10'd1;
        endcase
    endfunction

    logic [1:0]                 state_q, state_d;
    logic [2:0]                 speed_q;
    logic                       spd_inv_q;
    logic [35:0]                prev_q;
    logic [35:0]                cap_q, cap_d;
    logic [35:0]                out_q, out_d;
    logic                       valid_q, valid_d;
    logic [9:0]                 phase_q, phase_d;
    logic                       grp_err_q, grp_err_d;
    logic [3:0]                 err_grp_q, err_grp_d;
    logic [TO_W-1:0]            timeout_q, timeout_d;
    logic [p_ERR_CNT_WIDTH-1:0] rep_err_q, rep_err_d;

    logic [35:0] in_word;
    logic        speed_valid;
    logic        speed_change;
    logic [9:0]  last_phase;
    logic        mismatch;

    assign in_word      = {i_usxgmii_control, i_usxgmii_data};
    assign speed_valid  = (i_speed < 3'd6);
    assign speed_change = (speed_q != i_speed);
    assign last_phase   = rep_factor(speed_q) - 10'd1;
    assign mismatch     = (state_q == S_RUN) && (phase_q != 10'd0) && (in_word != cap_q);

    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        phase_d   = phase_q;
        grp_err_d = grp_err_q;
        err_grp_d = err_grp_q;
        timeout_d = timeout_q;
        rep_err_d = rep_err_q;

        if (!i_link_up || !speed_valid) begin
            state_d   = S_IDLE;
            phase_d   = 10'd0;
            timeout_d = '0;
            grp_err_d = 1'b0;
            err_grp_d = 4'd0;
        end else if (state_q != S_IDLE && speed_change) begin
            state_d   = S_ALIGN;
            phase_d   = 10'd0;
            timeout_d = '0;
            grp_err_d = 1'b0;
            err_grp_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = (rep_factor(i_speed) == 10'd1) ? S_RUN : S_ALIGN;
                    phase_d   = 10'd0;
                    timeout_d = '0;
                end
                S_ALIGN: begin
                    // A word change (or the timeout) marks the start of a replication group.
                    if (in_word != prev_q || timeout_q == TO_LAST) begin
                        cap_d     = in_word;
                        out_d     = in_word;
                        valid_d   = 1'b1;
                        phase_d   = (last_phase == 10'd0) ? 10'd0 : 10'd1;
                        state_d   = S_RUN;
                        timeout_d = '0;
                        grp_err_d = 1'b0;
                    end else begin
                        timeout_d = timeout_q + 1'b1;
                    end
                end
                S_RUN: begin
                    phase_d = (phase_q == last_phase) ? 10'd0 : phase_q + 10'd1;
                    if (phase_q == 10'd0) begin
                        cap_d   = in_word;
                        out_d   = in_word;
                        valid_d = 1'b1;
                    end
                    if (mismatch && rep_err_q != '1)
                        rep_err_d = rep_err_q + 1'b1;
                    if (last_phase != 10'd0 && phase_q == last_phase) begin
                        grp_err_d = 1'b0;
                        if (grp_err_q || mismatch) begin
                            if (err_grp_q + 4'd1 >= ERR_LIM) begin
                                state_d   = S_ALIGN;
                                phase_d   = 10'd0;
                                err_grp_d = 4'd0;
                            end else begin
                                err_grp_d = err_grp_q + 4'd1;
                            end
                        end else begin
                            err_grp_d = 4'd0;
                        end
                    end else begin
                        grp_err_d = grp_err_q | mismatch;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_usxgmii_clock) begin
        if (i_usxgmii_reset) begin
            state_q   <= S_IDLE;
            speed_q   <= 3'd0;
            spd_inv_q <= 1'b0;
            prev_q    <= IDLE_WORD;
            cap_q     <= IDLE_WORD;
            out_q     <= IDLE_WORD;
            valid_q   <= 1'b0;
            phase_q   <= 10'd0;
            grp_err_q <= 1'b0;
            err_grp_q <= 4'd0;
            timeout_q <= '0;
            rep_err_q <= '0;
        end else begin
            state_q   <= state_d;
            speed_q   <= i_speed;
            spd_inv_q <= !speed_valid;
            prev_q    <= in_word;
            cap_q     <= cap_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            phase_q   <= phase_d;
            grp_err_q <= grp_err_d;
            err_grp_q <= err_grp_d;
            timeout_q <= timeout_d;
            rep_err_q <= rep_err_d;
        end
    end

    assign o_usxgmii_valid   = valid_q;
    assign o_usxgmii_control = out_q[35:32];
    assign o_usxgmii_data    = out_q[31:0];
    assign o_locked          = (state_q == S_RUN);
    assign o_speed_invalid   = spd_inv_q;
    assign o_rep_err_count   = rep_err_q;

endmodule

// File: tb/tb_usxgmii_rate_adapt_ctrl.sv
// Scoreboard bench for usxgmii_rate_adapt_ctrl: expected forwarded words and
// their strobe cycle are queued at drive time and matched by a valid monitor.
module tb_usxgmii_rate_adapt_ctrl;

    localparam logic [3:0]  IDLE_C = 4'hF;
    localparam logic [31:0] IDLE_D = 32'h0707_0707;

    typedef struct {
        logic [35:0] word;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_up;
    logic [2:0]  speed;
    logic [3:0]  in_c;
    logic [31:0] in_d;
    logic        o_valid;
    logic [3:0]  o_c;
    logic [31:0] o_d;
    logic        o_locked;
    logic        o_inv;
    logic [15:0] o_rep;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    usxgmii_rate_adapt_ctrl dut (
        .i_usxgmii_clock  (clk),
        .i_usxgmii_reset  (rst),
        .i_link_up        (link_up),
        .i_speed          (speed),
        .i_usxgmii_control(in_c),
        .i_usxgmii_data   (in_d),
        .o_usxgmii_valid  (o_valid),
        .o_usxgmii_control(o_c),
        .o_usxgmii_data   (o_d),
        .o_locked         (o_locked),
        .o_speed_invalid  (o_inv),
        .o_rep_err_count  (o_rep)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Valid monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("valid_word", {28'd0, o_c, o_d}, {28'd0, e.word});
                check("valid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Apply one input word for one cycle; returns #1 after the consuming edge.
    task automatic step(input logic [3:0] c, input logic [31:0] d, input bit push);
        exp_t e;
        in_c = c;
        in_d = d;
        if (push) begin
            e.word = {c, d};
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        link_up = 1'b0;
        step(IDLE_C, IDLE_D, 1'b0);
        step(IDLE_C, IDLE_D, 1'b0);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        step(IDLE_C, IDLE_D, 1'b0);
        step(IDLE_C, IDLE_D, 1'b0);
        check(tag, 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        rst = 1'b1; link_up = 1'b0; speed = 3'd5; in_c = IDLE_C; in_d = IDLE_D;
        #1;
        do_reset();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ctrl", 64'(o_c), 64'hF);
        check("rst_data", 64'(o_d), 64'h0707_0707);
        check("rst_locked", 64'(o_locked), 64'd0);
        check("rst_inv", 64'(o_inv), 64'd0);
        check("rst_rep", 64'(o_rep), 64'd0);

        // 10G: no replication, every word forwarded one cycle later.
        speed = 3'd5; link_up = 1'b1;
        step(IDLE_C, IDLE_D, 1'b0);
        check("10g_locked", 64'(o_locked), 64'd1);
        for (int i = 0; i < 8; i++)
            step(4'(i), 32'hC0DE_0000 + 32'(i * 7919), 1'b1);
        link_up = 1'b0;
        drain("10g_drain");
        check("10g_unlocked", 64'(o_locked), 64'd0);

        // 1G alignment after idle, words held 10 cycles each.
        do_reset();
        speed = 3'd2; link_up = 1'b1;
        for (int i = 0; i < 30; i++) step(IDLE_C, IDLE_D, 1'b0);
        check("1g_align_unlocked", 64'(o_locked), 64'd0);
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 10; k++)
                step(4'd0, 32'h0A0A_0A0A * 32'(g + 1), k == 0);
        check("1g_locked", 64'(o_locked), 64'd1);
        link_up = 1'b0;
        drain("1g_drain");
        check("1g_rep", 64'(o_rep), 64'd0);

        // 2.5G replication errors: one isolated, then four consecutive groups.
        do_reset();
        speed = 3'd3; link_up = 1'b1;
        for (int i = 0; i < 3; i++) step(IDLE_C, IDLE_D, 1'b0);
        for (int g = 0; g < 9; g++) begin
            if (g == 2) begin
                check("25g_single_rep", 64'(o_rep), 64'd1);
                check("25g_single_locked", 64'(o_locked), 64'd1);
            end
            if (g == 8) check("25g_limit_unlocked", 64'(o_locked), 64'd0);
            w = 32'hA000_0000 + 32'(g);
            for (int k = 0; k < 4; k++) begin
                if (k == 3 && (g == 1 || (g >= 4 && g <= 7)))
                    step(4'd0, w ^ 32'h1, 1'b0);
                else
                    step(4'd0, w, k == 0);
            end
        end
        check("25g_relocked", 64'(o_locked), 64'd1);
        check("25g_rep_total", 64'(o_rep), 64'd5);
        link_up = 1'b0;
        drain("25g_drain");

        // 100M group interrupted at phase 50 by a change to 5G.
        do_reset();
        speed = 3'd1; link_up = 1'b1;
        for (int i = 0; i < 4; i++) step(IDLE_C, IDLE_D, 1'b0);
        step(4'h1, 32'h1111_1111, 1'b1);
        for (int i = 1; i < 50; i++) step(4'h1, 32'h1111_1111, 1'b0);
        speed = 3'd4;
        step(4'h1, 32'h1111_1111, 1'b0);
        check("spd_chg_unlocked", 64'(o_locked), 64'd0);
        for (int i = 0; i < 3; i++) step(4'h1, 32'h1111_1111, 1'b0);
        for (int g = 0; g < 3; g++) begin
            step(4'h2, 32'h2222_0000 + 32'(g), 1'b1);
            step(4'h2, 32'h2222_0000 + 32'(g), 1'b0);
        end
        check("5g_locked", 64'(o_locked), 64'd1);

        // Link loss in RUN: back to IDLE, outputs hold the last word.
        link_up = 1'b0;
        step(4'h3, 32'h3333_3333, 1'b0);
        check("linkloss_locked", 64'(o_locked), 64'd0);
        check("linkloss_valid", 64'(o_valid), 64'd0);
        step(4'h3, 32'h3333_3334, 1'b0);
        check("linkloss_hold", {28'd0, o_c, o_d}, {28'd0, 4'h2, 32'h2222_0002});
        check("linkloss_inv", 64'(o_inv), 64'd0);

        // Invalid speed keeps the FSM in IDLE even with changing words.
        speed = 3'd7; link_up = 1'b1;
        step(4'h4, 32'h4444_0001, 1'b0);
        check("inv_flag", 64'(o_inv), 64'd1);
        step(4'h4, 32'h4444_0002, 1'b0);
        step(4'h4, 32'h4444_0003, 1'b0);
        check("inv_locked", 64'(o_locked), 64'd0);
        check("inv_q_empty", 64'(q.size()), 64'd0);

        // 10M reset in the middle of a group.
        do_reset();
        speed = 3'd0; link_up = 1'b1;
        step(IDLE_C, IDLE_D, 1'b0);
        step(IDLE_C, IDLE_D, 1'b0);
        step(4'h5, 32'h5555_AAAA, 1'b1);
        for (int i = 1; i < 10; i++) step(4'h5, 32'h5555_AAAA, 1'b0);
        step(4'h5, 32'h5555_AAAB, 1'b0);
        for (int i = 11; i < 500; i++) step(4'h5, 32'h5555_AAAA, 1'b0);
        check("10m_rep", 64'(o_rep), 64'd1);
        check("10m_locked", 64'(o_locked), 64'd1);
        rst = 1'b1;
        step(4'h5, 32'h5555_AAAA, 1'b0);
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_word", {28'd0, o_c, o_d}, {28'd0, IDLE_C, IDLE_D});
        check("midrst_locked", 64'(o_locked), 64'd0);
        check("midrst_inv", 64'(o_inv), 64'd0);
        check("midrst_rep", 64'(o_rep), 64'd0);
        rst = 1'b0;
        link_up = 1'b0;
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
